seq_pack: RTL and testbench
===========================

# seq_pack

Downstream packer for the serial sequence extractor. It accepts the extractor's qualified bit stream (`dout_vld`/`dout`, wired to `din_vld`/`din` here) and assembles bits MSB-first into DATA_W-bit words. Words go into a small synchronous FIFO and leave through a valid/ready interface toward the parallel consumer. A flush input forces out a partial word, and a sticky flag records any word lost to a full FIFO.

## Interface
- DATA_W, 8: word width in bits; ≥2
- DEPTH, 4: FIFO entries; power of two, ≥2
- LEN_W, $clog2(DATA_W)+1: width of the valid-bit count
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- din_vld  in  1  qualifies din this cycle
- din  in  1  serial bit, MSB of word first
- flush  in  1  emit pending partial word
- dout_rdy  in  1  consumer accepts head word
- dout_vld  out  1  FIFO non-empty
- dout  out  DATA_W  head word, left-aligned, zero-padded LSBs
- dout_len  out  LEN_W  number of valid bits in dout (1..DATA_W)
- overflow  out  1  sticky: a word was dropped because the FIFO was full

## Operation
- Packer state: shift_reg[DATA_W-1:0] and bit_cnt (0..DATA_W-1). bit_cnt==0 is IDLE; nonzero is COLLECT.
- A cycle with din_vld is an accepted bit: shift_reg <= {shift_reg[DATA_W-2:0], din}, and bit_cnt increments.
- Word complete: din_vld with bit_cnt==DATA_W-1.
  - Pushes {shift_reg[DATA_W-2:0], din} with len=DATA_W.
  - bit_cnt wraps to 0.
- Flush with bit_cnt==n>0 and no din_vld:
  - Pushes shift_reg[n-1:0] left-aligned (zero LSBs) with len=n.
  - bit_cnt returns to 0.
- Flush together with din_vld:
  - The bit is taken first; pushes n+1 bits.
  - If that completes a word, it is a normal full push; nothing else is emitted.
- Flush in IDLE without din_vld: no-op. No zero-length words are ever pushed.
- At most one push per cycle.
- FIFO pop: dout_vld && dout_rdy.
- Push while full:
  - With a simultaneous pop: accepted.
  - Otherwise: word discarded, overflow <= 1, and the packer still wraps to 0.
- overflow clears only on reset.
- dout/dout_len are the FIFO head and are stable while dout_vld && !dout_rdy.

## Timing
- Reset values: dout_vld=0, dout=0, dout_len=0, overflow=0; bit_cnt=0, shift_reg=0, FIFO empty.
- Latency: the completing bit is sampled at edge k; dout_vld=1 during cycle k+1 (one cycle).
- No combinational path from din/din_vld/flush to outputs.
- dout_vld depends only on registered FIFO count; dout_rdy affects only next-state.
- Throughput: one word per cycle on output; input one bit per cycle sustained.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits (0..DEPTH).
- Simultaneous push and pop:
  - Non-empty, non-full: count unchanged.
  - Empty: word appears next cycle; the pop side sees nothing this cycle.
- Reset mid-word or mid-FIFO: partial bits and stored words are discarded immediately (async). Operation resumes at the first edge after release.

## Structure
- Package seq_pkg: DATA_W, DEPTH, LEN_W defaults, and a packed struct seq_word_t {data[DATA_W-1:0], len[LEN_W-1:0]}.
- Sub-module seq_fifo:
  - Synchronous FIFO of seq_word_t.
  - Ports: push/pop/full/empty/head.
  - Registered count; pop-while-empty and push-while-full-without-pop are ignored.
- seq_pack contains the packer register set, the flush/overflow logic, and one seq_fifo instance.

## Test plan
- Bits 1,0,1,1,0,0,1,0 on consecutive cycles, dout_rdy=1 → dout_vld one cycle after the 8th bit, dout=8'hB2, dout_len=8, overflow=0.
- Bits 1,1,0 then flush alone → dout=8'hC0, dout_len=3. A second flush alone → no further word.
- Bits 1,0,1 with flush asserted on the 3rd bit → dout=8'hA0, dout_len=3. A 7-bit prefix plus an 8th bit with flush → one word, len=8.
- dout_rdy=0, stream 5 full words 8'h01..8'h05 → FIFO holds 01..04, overflow=1. Then dout_rdy=1 → pops 01,02,03,04 in order.
- FIFO full; push and pop in the same cycle → both succeed, overflow stays 0, order preserved.
- rst_n low after 4 bits and with 2 words queued → outputs 0 immediately. After release, 8 fresh bits 8'hFF → single word 8'hFF, len=8.

Source files
------------

// File: rtl/seq_pack_pkg.sv
// Shared defaults and the word record that travels through the packer FIFO.
package seq_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = $clog2(DATA_W) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } seq_word_t;

endpackage

// File: rtl/seq_pack_if.sv
// Serial-in / word-out handshake bundle between the extractor, the packer and its consumer.
interface seq_pack_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);

  logic              din_vld;
  logic              din;
  logic              flush;
  logic              dout_rdy;
  logic              dout_vld;
  logic [DATA_W-1:0] dout;
  logic [LEN_W-1:0]  dout_len;
  logic              overflow;

  modport master (
    output din_vld, din, flush, dout_rdy,
    input  dout_vld, dout, dout_len, overflow
  );

  modport slave (
    input  din_vld, din, flush, dout_rdy,
    output dout_vld, dout, dout_len, overflow
  );

endinterface

// File: rtl/seq_pack_fifo.sv
// Small synchronous FIFO with a registered occupancy count; a push while full is
// accepted only when a pop frees the head slot in the same cycle.
module seq_fifo
  import seq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = seq_pkg::seq_word_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;
  T                 mem_q [DEPTH];

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/seq_pack.sv
// Packs a qualified serial bit stream MSB-first into words, with flush of partial
// words, a small output FIFO and a sticky overflow flag for dropped words.
module seq_pack #(
  parameter int DATA_W = seq_pkg::DATA_W,
  parameter int DEPTH  = seq_pkg::DEPTH,
  parameter int LEN_W  = seq_pkg::LEN_W
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_pack_if.slave  bus
);

  import seq_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } word_t;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] shifted;
  logic [LEN_W-1:0]  n_bits;
  logic              push;
  word_t             push_word;
  word_t             head;
  logic              full, empty, pop_fire;

  assign pop_fire = !empty && bus.dout_rdy;

  always_comb begin
    shifted   = {shift_q[DATA_W-2:0], bus.din};
    n_bits    = LEN_W'(bit_cnt_q);
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    push      = 1'b0;
    push_word = '0;
    if (bus.din_vld) begin
      shift_d = shifted;
      if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
        push           = 1'b1;
        push_word.data = shifted;
        push_word.len  = LEN_W'(DATA_W);
        bit_cnt_d      = '0;
      end else if (bus.flush) begin
        // The incoming bit counts toward the flushed word: n+1 bits, left-aligned.
        push           = 1'b1;
        push_word.data = shifted << (LEN_W'(DATA_W - 1) - n_bits);
        push_word.len  = n_bits + LEN_W'(1);
        bit_cnt_d      = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (bus.flush && bit_cnt_q != '0) begin
      push           = 1'b1;
      push_word.data = shift_q << (LEN_W'(DATA_W) - n_bits);
      push_word.len  = n_bits;
      bit_cnt_d      = '0;
    end
    overflow_d = overflow_q || (push && full && !pop_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  seq_fifo #(
    .DEPTH (DEPTH),
    .T     (word_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (bus.dout_rdy),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Stale storage is masked so an empty FIFO always presents zeros.
  assign bus.dout_vld = !empty;
  assign bus.dout     = empty ? '0 : head.data;
  assign bus.dout_len = empty ? '0 : head.len;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seq_pack.sv
// Directed and random stimulus for seq_pack, checked against a bit-queue / word-queue model.
module tb_seq_pack;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 4;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  bit          pend [$];
  logic [7:0]  q_data [$];
  logic [3:0]  q_len [$];
  bit          m_ovf;

  seq_pack_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  seq_pack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    q_data.delete();
    q_len.delete();
    m_ovf = 1'b0;
  endtask

  // One clock edge of the reference behaviour: pop from the old head, then pack/push.
  task automatic model_edge(input bit v, input bit b, input bit f, input bit r);
    logic [7:0] w;
    if (r && q_data.size() > 0) begin
      void'(q_data.pop_front());
      void'(q_len.pop_front());
    end
    if (v) pend.push_back(b);
    if (pend.size() == DATA_W || (f && pend.size() > 0)) begin
      w = '0;
      for (int i = 0; i < pend.size(); i++) w[DATA_W-1-i] = pend[i];
      if (q_data.size() < DEPTH) begin
        q_data.push_back(w);
        q_len.push_back(4'(pend.size()));
      end else begin
        m_ovf = 1'b1;
      end
      pend.delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    bit nonempty;
    nonempty = (q_data.size() > 0);
    chk({tag, ".vld"}, 32'(bus.dout_vld), 32'(nonempty));
    chk({tag, ".dout"}, 32'(bus.dout), nonempty ? 32'(q_data[0]) : 32'd0);
    chk({tag, ".len"}, 32'(bus.dout_len), nonempty ? 32'(q_len[0]) : 32'd0);
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic step(input bit v, input bit b, input bit f, input bit r, input string tag);
    bus.din_vld  = v;
    bus.din      = b;
    bus.flush    = f;
    bus.dout_rdy = r;
    @(posedge clk);
    model_edge(v, b, f, r);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic send_word(input logic [7:0] w, input bit r_body, input bit r_last, input string tag);
    for (int i = DATA_W - 1; i >= 1; i--) step(1'b1, w[i], 1'b0, r_body, tag);
    step(1'b1, w[0], 1'b0, r_last, tag);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.din_vld  = 1'b0;
    bus.din      = 1'b0;
    bus.flush    = 1'b0;
    bus.dout_rdy = 1'b0;
    model_reset();
    #12;
    chk("reset.vld", 32'(bus.dout_vld), 32'd0);
    chk("reset.dout", 32'(bus.dout), 32'd0);
    chk("reset.len", 32'(bus.dout_len), 32'd0);
    chk("reset.ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send_word(8'hB2, 1'b1, 1'b1, "b2");
    chk("b2.const", 32'(bus.dout), 32'h B2);
    chk("b2.len_const", 32'(bus.dout_len), 32'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, "idle");

    step(1'b1, 1'b1, 1'b0, 1'b1, "c0");
    step(1'b1, 1'b1, 1'b0, 1'b1, "c0");
    step(1'b1, 1'b0, 1'b0, 1'b1, "c0");
    step(1'b0, 1'b0, 1'b1, 1'b1, "c0.flush");
    chk("c0.const", 32'(bus.dout), 32'h C0);
    chk("c0.len_const", 32'(bus.dout_len), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b1, "flush_idle");
    chk("flush_idle.vld_const", 32'(bus.dout_vld), 32'd0);

    step(1'b1, 1'b1, 1'b0, 1'b1, "a0");
    step(1'b1, 1'b0, 1'b0, 1'b1, "a0");
    step(1'b1, 1'b1, 1'b1, 1'b1, "a0.flush");
    chk("a0.const", 32'(bus.dout), 32'h A0);
    chk("a0.len_const", 32'(bus.dout_len), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, "idle");
    for (int i = 0; i < 7; i++) step(1'b1, i[0], 1'b0, 1'b1, "full_flush");
    step(1'b1, 1'b1, 1'b1, 1'b1, "full_flush.last");
    chk("full_flush.len_const", 32'(bus.dout_len), 32'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, "full_flush.single");
    chk("full_flush.single_const", 32'(bus.dout_vld), 32'd0);

    for (int w = 8'h10; w < 8'h14; w++) send_word(8'(w), 1'b0, 1'b0, "fill");
    send_word(8'h14, 1'b0, 1'b1, "pushpop");
    chk("pushpop.ovf_const", 32'(bus.overflow), 32'd0);
    chk("pushpop.head_const", 32'(bus.dout), 32'h11);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "pushpop.drain");

    for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0, 1'b0, "ovf");
    chk("ovf.flag_const", 32'(bus.overflow), 32'd1);
    for (int w = 1; w <= 4; w++) begin
      chk("ovf.order_const", 32'(bus.dout), 32'(w));
      step(1'b0, 1'b0, 1'b0, 1'b1, "ovf.drain");
    end
    chk("ovf.empty_const", 32'(bus.dout_vld), 32'd0);

    send_word(8'h21, 1'b0, 1'b0, "rst_prep");
    send_word(8'h22, 1'b0, 1'b0, "rst_prep");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "rst_prep");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.vld", 32'(bus.dout_vld), 32'd0);
    chk("midrst.dout", 32'(bus.dout), 32'd0);
    chk("midrst.len", 32'(bus.dout_len), 32'd0);
    chk("midrst.ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'hFF, 1'b1, 1'b1, "ff");
    chk("ff.const", 32'(bus.dout), 32'h FF);
    chk("ff.len_const", 32'(bus.dout_len), 32'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, "ff.single");

    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
